// File: rtl/mem_multicycle_if.sv
// mem_multicycle_if: instruction and data port bundle for mem_multicycle.
//   Read_PC/Instruction       : instruction fetch port, 1-cycle registered read
//   R_W_Addr/DataWrite/ByteEn : data-port request payload
//   Op2En/Op2RW               : data-port request strobe and type (1 = write)
//   Op2Ready/DataRead         : completion pulse and read result
//   Busy                      : high while the clear sweep runs
// master drives requests (CPU side), slave is the memory.
interface mem_multicycle_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   Read_PC;
    logic [DATA_W-1:0]   Instruction;
    logic [ADDR_W-1:0]   R_W_Addr;
    logic [DATA_W-1:0]   DataWrite;
    logic [DATA_W/8-1:0] ByteEn;
    logic                Op2En;
    logic                Op2RW;
    logic                Op2Ready;
    logic [DATA_W-1:0]   DataRead;
    logic                Busy;

    modport master (
        output Read_PC, R_W_Addr, DataWrite, ByteEn, Op2En, Op2RW,
        input  Instruction, Op2Ready, DataRead, Busy
    );

    modport slave (
        input  Read_PC, R_W_Addr, DataWrite, ByteEn, Op2En, Op2RW,
        output Instruction, Op2Ready, DataRead, Busy
    );
endinterface

// File: rtl/mem_multicycle.sv
// mem_multicycle: word-organised memory with a single-cycle instruction port
// and a multi-cycle (LATENCY) data port with byte-enabled writes.
//   clk     : sole clock, rising edge
//   M_Clear : synchronous active-high reset; starts a zeroing sweep of all words
//   bus     : mem_multicycle_if.slave (instruction port, data port, Busy)
// After M_Clear falls the array is swept to zero, one word per cycle, with
// Busy high. Data requests are captured on acceptance and complete LATENCY
// edges later; Op2Ready pulses for the cycle after the completion edge.
module mem_multicycle #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             M_Clear,
    mem_multicycle_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT} state_t;

    state_t                  state;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   ptr;
    logic [2:0]              cnt;       // edges elapsed since acceptance

    // captured request
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [DATA_W-1:0]       req_wdata;
    logic [NB-1:0]           req_be;
    logic                    req_rw;

    logic [DATA_W-1:0]       instr_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    ready_q;
    logic                    busy_q;

    logic [DEPTH_LOG2-1:0]   pc_idx;
    logic [DEPTH_LOG2-1:0]   rw_idx;
    logic                    completing;
    logic                    accept;

    // Only the word index is used; byte-offset and high bits wrap.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{bus.Read_PC, bus.R_W_Addr};

    assign pc_idx = bus.Read_PC[DEPTH_LOG2+1:2];
    assign rw_idx = bus.R_W_Addr[DEPTH_LOG2+1:2];

    // The edge that completes a request is also the edge at which the
    // requester observes the completion, so a held Op2En is accepted right
    // there. This gives one request per LATENCY cycles back-to-back; Op2En
    // during the earlier WAIT edges is simply dropped.
    assign completing = (state == WAIT) && (cnt == 3'(LATENCY));
    assign accept     = bus.Op2En && ((state == IDLE) || completing);

    always_ff @(posedge clk) begin
        if (M_Clear) begin
            state   <= CLEAR;
            ptr     <= '0;
            cnt     <= '0;
            instr_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            ready_q <= 1'b0;
            if (state == CLEAR) begin
                instr_q  <= '0;
                mem[ptr] <= '0;
                ptr      <= ptr + 1'b1;
                if (&ptr) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            end else begin
                // Nonblocking read: a same-edge write commit is not visible.
                instr_q <= mem[pc_idx];

                if (completing) begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                    if (req_rw) begin
                        for (int b = 0; b < NB; b++) begin
                            if (req_be[b])
                                mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                        end
                    end else begin
                        rdata_q <= mem[req_idx];
                    end
                end else if (state == WAIT) begin
                    cnt <= cnt + 3'd1;
                end

                if (accept) begin
                    req_idx   <= rw_idx;
                    req_wdata <= bus.DataWrite;
                    req_be    <= bus.ByteEn;
                    req_rw    <= bus.Op2RW;
                    cnt       <= 3'd1;
                    state     <= WAIT;
                end
            end
        end
    end

    assign bus.Instruction = instr_q;
    assign bus.DataRead    = rdata_q;
    assign bus.Op2Ready    = ready_q;
    assign bus.Busy        = busy_q;
endmodule

// File: tb/tb_mem_multicycle.sv
module tb_mem_multicycle;
    logic clk = 1'b0;
    logic M_Clear;

    mem_multicycle_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_multicycle #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(4), .LATENCY(2)
    ) dut (
        .clk    (clk),
        .M_Clear(M_Clear),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; lat = edges from acceptance to Op2Ready seen.
    task automatic do_op(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat);
        bus.Op2En     = 1'b1;
        bus.Op2RW     = rw;
        bus.R_W_Addr  = addr;
        bus.DataWrite = wdata;
        bus.ByteEn    = be;
        step();
        // scramble payload after acceptance: must not leak into the request
        bus.Op2En     = 1'b0;
        bus.Op2RW     = ~rw;
        bus.R_W_Addr  = 32'h0000_0030;
        bus.DataWrite = 32'h5A5A_5A5A;
        bus.ByteEn    = 4'hF;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus.Op2Ready && lat < 20);
    endtask

    task automatic wait_sweep(output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (bus.Busy && n < 100) begin
            n++;
            step();
            if (bus.Op2Ready) pulses++;
        end
    endtask

    initial begin
        int lat, n, pulses;
        logic [31:0] prev_rd;
        logic [31:0] b2b_addr[4];
        logic [31:0] b2b_exp[4];

        vecs[0] = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 32'h08, 32'h0,       4'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'b0101, 32'h0};
        vecs[3] = '{1'b0, 32'h44, 32'h0,       4'h0, 32'h00FF00FF};
        vecs[4] = '{1'b1, 32'h3C, 32'hAABBCCDD, 4'hF, 32'h0};
        vecs[5] = '{1'b1, 32'h7C, 32'h11223344, 4'b1010, 32'h0};
        vecs[6] = '{1'b0, 32'h3E, 32'h0,       4'h0, 32'h11BB33DD};
        vecs[7] = '{1'b0, 32'h08, 32'h0,       4'h0, 32'hDEADBEEF};

        b2b_addr = '{32'h08, 32'h04, 32'h3C, 32'h00};
        b2b_exp  = '{32'hDEADBEEF, 32'h00FF00FF, 32'h11BB33DD, 32'h0};

        M_Clear       = 1'b1;
        bus.Read_PC   = '0;
        bus.R_W_Addr  = '0;
        bus.DataWrite = '0;
        bus.ByteEn    = '0;
        bus.Op2En     = 1'b0;
        bus.Op2RW     = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(bus.Busy), 32'd1);
        chk("rst_ready", 32'(bus.Op2Ready), 32'd0);
        chk("rst_instr", bus.Instruction, 32'h0);
        chk("rst_dataread", bus.DataRead, 32'h0);

        M_Clear = 1'b0;
        wait_sweep(n, pulses);
        chk("clear_busy_cycles", 32'(n), 32'd16);

        for (int a = 0; a < 64; a += 4) begin
            do_op(1'b0, 32'(a), 32'h0, 4'h0, lat);
            chk("clear_read", bus.DataRead, 32'h0);
        end

        // table-driven write/read vectors
        prev_rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            if (!vecs[i].rw) prev_rd = vecs[i].exp_rd;
            chk($sformatf("vec%0d_dataread", i), bus.DataRead, prev_rd);
            step();
            chk($sformatf("vec%0d_pulse_width", i), 32'(bus.Op2Ready), 32'd0);
        end

        // instruction port reads current contents
        bus.Read_PC = 32'h08;
        step();
        chk("instr_read", bus.Instruction, 32'hDEADBEEF);

        // back-to-back reads with Op2En held
        bus.Op2En = 1'b1;
        bus.Op2RW = 1'b0;
        bus.R_W_Addr = b2b_addr[0];
        step();                     // accepts first
        bus.R_W_Addr = b2b_addr[1];
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.Op2Ready) pulses++;
            chk($sformatf("b2b_ready_k%0d", k), 32'(bus.Op2Ready),
                32'((k % 2 == 0) && (k <= 8)));
            if (k % 2 == 0 && k <= 8)
                chk($sformatf("b2b_data_k%0d", k), bus.DataRead, b2b_exp[k/2-1]);
            if (k == 2) bus.R_W_Addr = b2b_addr[2];
            if (k == 4) bus.R_W_Addr = b2b_addr[3];
            if (k == 6) bus.Op2En = 1'b0;
        end
        chk("b2b_pulse_count", 32'(pulses), 32'd4);

        // write commit vs instruction fetch at the same edge
        bus.Read_PC   = 32'h10;
        bus.Op2En     = 1'b1;
        bus.Op2RW     = 1'b1;
        bus.R_W_Addr  = 32'h10;
        bus.DataWrite = 32'h12345678;
        bus.ByteEn    = 4'hF;
        step();                     // accept
        bus.Op2En = 1'b0;
        step();
        chk("instr_pre_e1", bus.Instruction, 32'h0);
        step();                     // commit edge
        chk("instr_commit_ready", 32'(bus.Op2Ready), 32'd1);
        chk("instr_commit_old", bus.Instruction, 32'h0);
        step();
        chk("instr_commit_new", bus.Instruction, 32'h12345678);

        // reset one cycle after a write is accepted
        bus.Read_PC   = 32'h08;
        bus.Op2En     = 1'b1;
        bus.Op2RW     = 1'b1;
        bus.R_W_Addr  = 32'h14;
        bus.DataWrite = 32'hCAFEF00D;
        bus.ByteEn    = 4'hF;
        step();                     // accept
        M_Clear = 1'b1;
        step();                     // reset edge
        chk("midop_busy", 32'(bus.Busy), 32'd1);
        chk("midop_ready", 32'(bus.Op2Ready), 32'd0);
        M_Clear = 1'b0;
        // Op2En stays high through the sweep and must be ignored
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.Op2Ready) pulses++;
        end
        chk("sweep_instr_zero", bus.Instruction, 32'h0);
        // restart the sweep mid-way
        M_Clear = 1'b1;
        step();
        M_Clear = 1'b0;
        wait_sweep(n, lat);
        pulses += lat;
        bus.Op2En = 1'b0;
        chk("restart_busy_cycles", 32'(n), 32'd16);
        chk("sweep_no_ready", 32'(pulses), 32'd0);

        do_op(1'b0, 32'h14, 32'h0, 4'h0, lat);
        chk("midop_target_zero", bus.DataRead, 32'h0);
        do_op(1'b0, 32'h08, 32'h0, 4'h0, lat);
        chk("post_sweep_zero", bus.DataRead, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_multicycle.md
MEM_MULTICYCLE -- requirements
Module: mem_multicycle

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, word width; multiple of 8.
- ADDR_W, 32, byte-address width.
- DEPTH_LOG2, 8, log2 of word count (DEPTH = 2**DEPTH_LOG2).
- LATENCY, 2, data-port access latency in cycles; legal range 1..7.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; rising edge.
- M_Clear, in, 1, synchronous active-high reset plus memory clear.
- Read_PC, in, ADDR_W, instruction-port byte address.
- Instruction, out, DATA_W, registered instruction read data.
- R_W_Addr, in, ADDR_W, data-port byte address.
- DataWrite, in, DATA_W, data-port write data.
- ByteEn, in, DATA_W/8, per-byte write enable; bit i covers bits [8i+7:8i].
- Op2En, in, 1, data-port request.
- Op2RW, in, 1, request type: 1 = write, 0 = read.
- Op2Ready, out, 1, one-cycle completion pulse.
- DataRead, out, DATA_W, data-port read result; held between reads.
- Busy, out, 1, high while the clear sweep runs.

Function
REQ-003 Word index SHALL be address bits [DEPTH_LOG2+1:2]; bits [1:0] and bits above the index SHALL be ignored, so out-of-range addresses wrap.
REQ-004 The FSM SHALL have three states: CLEAR (Busy=1), IDLE, WAIT.
REQ-005 Instruction SHALL update every non-reset edge to the word indexed by Read_PC at that edge (1-cycle latency), independent of data-port activity, and SHALL hold 0 while in CLEAR.
REQ-006 A request SHALL be accepted at an edge where Op2En=1 and the state is IDLE, or the state is WAIT with Op2Ready=1 (back-to-back acceptance).
REQ-007 On acceptance, R_W_Addr, DataWrite, ByteEn and Op2RW SHALL be captured; later input changes SHALL NOT affect the pending request.
REQ-008 Completion SHALL occur at the LATENCY-th edge after the accepting edge; Op2Ready SHALL be 1 for exactly the cycle following that edge.
REQ-009 At the completion edge, a write SHALL update only the bytes whose ByteEn bit is 1; a read SHALL load DataRead with the full word.
REQ-010 DataRead SHALL be unchanged by writes and by idle cycles.
REQ-011 Op2En=1 in WAIT while Op2Ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-012 Sustained back-to-back throughput SHALL be one request per LATENCY cycles.
REQ-013 If the instruction port reads a word at the same edge a write commits to it, Instruction SHALL return the pre-write value.
REQ-014 After Op2Ready, the FSM SHALL go to IDLE when no new request is accepted.
REQ-015 In CLEAR with M_Clear=0, each edge SHALL write zero to word ptr and increment ptr; at ptr=DEPTH-1 the next state SHALL be IDLE. Busy is therefore high for exactly DEPTH cycles after M_Clear falls.
REQ-016 Op2En SHALL be ignored in CLEAR, and Op2Ready SHALL stay 0 in CLEAR.

Reset
REQ-017 At any edge with M_Clear=1, the block SHALL set: state=CLEAR, ptr=0, Instruction=0, DataRead=0, Op2Ready=0, Busy=1.
REQ-018 A pending request SHALL be dropped by M_Clear without a memory update and without an Op2Ready pulse.
REQ-019 Asserting M_Clear mid-sweep SHALL restart the sweep at ptr=0.
REQ-020 After the sweep completes, every word SHALL read 0.

Verification
Bench parameters: DEPTH_LOG2=4, LATENCY=2.
REQ-021 Clear: M_Clear=1 for 2 cycles, then 0 -> Busy=1 for exactly 16 cycles; then a read of each of addrs 0..60 step 4 returns DataRead=0.
REQ-022 Write then read: write 0xDEADBEEF at 0x8, then read 0x8 -> Op2Ready pulses 2 cycles after each acceptance; DataRead=0xDEADBEEF.
REQ-023 Byte enables and wrap: write 0xFFFFFFFF at 0x4 with ByteEn=4'b0101, then read 0x44 -> DataRead=0x00FF00FF.
REQ-024 Back-to-back: Op2En held high for 4 reads -> Op2Ready pulses every 2 cycles; held Op2En between pulses does not create extra pulses.
REQ-025 Instruction port: write 0x12345678 at 0x10 while Read_PC=0x10 at the commit edge -> Instruction shows the old value, then 0x12345678 one cycle later.
REQ-026 Reset mid-operation: M_Clear=1 one cycle after a write is accepted -> no Op2Ready pulse; the target word reads 0 after the sweep.
